sha256_block_sequencer: RTL

SHA256_BLOCK_SEQUENCER -- requirements
Module: sha256_block_sequencer

---
 rtl/sha256_block_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sha256_block_sequencer.sv
// Streams a message of up to MAX_LEN bytes out of byte memory, pads it to one or two
// 512-bit SHA-256 blocks, and hands each block to an external compression core.
module sha256_block_sequencer #(
    parameter int MAX_LEN = 119
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic [6:0]   i_msg_len,
    output logic         o_mem_rd,
    output logic [6:0]   o_mem_addr,
    input  logic [7:0]   i_mem_data,
    output logic [511:0] o_core_block,
    output logic         o_core_first,
    output logic         o_core_start,
    input  logic         i_core_done,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err
);

    // state | meaning
    // IDLE  | waiting for a request
    // FILL  | 65 cycles: read bytes and shift the padded block in
    // START | one-cycle start pulse to the core
    // WAIT  | core compressing the current block
    // DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] MAX_LEN_C = 8'(MAX_LEN);

    state_t         state_q, state_d;
    logic [6:0]     len_q;
    logic           blk_q;
    logic [6:0]     cnt_q;
    logic [6:0]     addr_q;
    logic [511:0]   block_q;
    logic           first_q;
    logic           err_q;

    logic           len_ok;
    logic           last_blk;
    logic [6:0]     fill_g;
    logic           fill_rd;
    logic [5:0]     cap_b;
    logic [6:0]     cap_g;
    logic [15:0]    len_bits;
    logic [7:0]     cap_byte;

    assign len_ok   = ({1'b0, i_msg_len} <= MAX_LEN_C);
    assign last_blk = (len_q <= 7'd55) || blk_q;
    assign fill_g   = {blk_q, cnt_q[5:0]};
    assign fill_rd  = (state_q == S_FILL) && !cnt_q[6] && (fill_g < len_q);
    // Data for the byte read in cycle n arrives in cycle n+1, so capture lags by one.
    assign cap_b    = cnt_q[5:0] - 6'd1;
    assign cap_g    = {blk_q, cap_b};
    assign len_bits = {6'b0, len_q, 3'b000};

    always_comb begin
        cap_byte = 8'h00;
        if (last_blk && (cap_b == 6'd62)) begin
            cap_byte = len_bits[15:8];
        end else if (last_blk && (cap_b == 6'd63)) begin
            cap_byte = len_bits[7:0];
        end else if (last_blk && (cap_b >= 6'd56)) begin
            cap_byte = 8'h00;
        end else if (cap_g < len_q) begin
            cap_byte = i_mem_data;
        end else if (cap_g == len_q) begin
            cap_byte = 8'h80;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_start && len_ok) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (cnt_q == 7'd64) begin
                    state_d = S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (i_core_done) begin
                    state_d = last_blk ? S_DONE : S_FILL;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort outranks every other transition, including i_core_done in WAIT.
        if (i_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            len_q   <= 7'd0;
            blk_q   <= 1'b0;
            cnt_q   <= 7'd0;
            addr_q  <= 7'd0;
            block_q <= 512'd0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= (state_q == S_IDLE) && i_start && !len_ok;
            case (state_q)
                S_IDLE: begin
                    if (i_start && len_ok) begin
                        len_q <= i_msg_len;
                        blk_q <= 1'b0;
                        cnt_q <= 7'd0;
                    end
                end
                S_FILL: begin
                    cnt_q <= cnt_q + 7'd1;
                    if (fill_rd) begin
                        addr_q <= fill_g;
                    end
                    if (cnt_q != 7'd0) begin
                        block_q <= {block_q[503:0], cap_byte};
                    end
                    if (cnt_q == 7'd64) begin
                        first_q <= ~blk_q;
                    end
                end
                S_WAIT: begin
                    if (!i_abort && i_core_done && !last_blk) begin
                        blk_q <= 1'b1;
                        cnt_q <= 7'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_busy       = (state_q != S_IDLE);
        o_mem_rd     = fill_rd;
        o_mem_addr   = fill_rd ? fill_g : addr_q;
        o_core_start = (state_q == S_START) && !i_abort;
        o_done       = (state_q == S_DONE) && !i_abort;
        o_err        = err_q;
        o_core_block = block_q;
        o_core_first = first_q;
    end

endmodule
